sha2_msg_pad: RTL and testbench

- SHA-256 message padding stage.
- Sits between the HMAC message FIFO (32-bit data + 4-bit byte mask entries) and the compression/word-schedule engine.
- Forwards message words unchanged, then appends FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length.
- Output is a stream of 32-bit words in which every 16-word group is one complete 512-bit block.

---
 rtl/sha2_msg_pad.sv | 191 +++++++++++++++++++
 tb/tb_sha2_msg_pad.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_pad.sv
// rtl/sha2_msg_pad.sv - SHA-256 message padder (forward, 0x80, zero fill, 64-bit length)
// Optional byte-mask checking enabled by defining SHA2_MSG_PAD_MASK_CHK_EN.
module sha2_msg_pad #(
    parameter int unsigned LenW = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            sha_en_i,
    input  logic            hash_start_i,
    input  logic            hash_process_i,
    input  logic [LenW-1:0] message_length_i,
    input  logic            fifo_rvalid_i,
    input  logic [31:0]     fifo_rdata_i,
    input  logic [3:0]      fifo_rmask_i,
    output logic            fifo_rready_o,
    output logic            shaf_rvalid_o,
    output logic [31:0]     shaf_rdata_o,
    input  logic            shaf_rready_i,
    output logic            pad_done_o,
    output logic            err_mask_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_PAD00,
        ST_LENLO
    } state_e;

    state_e          state_q, state_d;
    logic [LenW-1:0] tx_cnt_q, tx_cnt_d;
    logic            proc_flag_q, proc_flag_d;

    logic [63:0]     len64;
    logic [3:0]      idx;
    logic [1:0]      tail_bytes;
    logic            partial_end;
    logic            aligned_end;
    logic [31:0]     pad_word;
    logic            xfer;

    logic            fifo_rready_c;
    logic            shaf_rvalid_c;
    logic [31:0]     shaf_rdata_c;
    logic            pad_done_c;

    assign len64      = 64'(message_length_i);
    assign idx        = tx_cnt_q[8:5];
    assign tail_bytes = message_length_i[4:3];

    // The final-word decision uses only the registered process flag, so a
    // process pulse coinciding with a full-word transfer never truncates it.
    assign partial_end = proc_flag_q && (tail_bytes != 2'd0) &&
                         (tx_cnt_q[LenW-1:5] == message_length_i[LenW-1:5]);
    assign aligned_end = proc_flag_q && (tail_bytes == 2'd0) &&
                         (tx_cnt_q == message_length_i);

    // Byte count of the last word comes from the length, never from the mask.
    always_comb begin
        pad_word = fifo_rdata_i;
        case (tail_bytes)
            2'd1:    pad_word = {fifo_rdata_i[31:24], 24'h800000};
            2'd2:    pad_word = {fifo_rdata_i[31:16], 16'h8000};
            2'd3:    pad_word = {fifo_rdata_i[31:8], 8'h80};
            default: pad_word = fifo_rdata_i;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        tx_cnt_d      = tx_cnt_q;
        proc_flag_d   = proc_flag_q | hash_process_i;
        fifo_rready_c = 1'b0;
        shaf_rvalid_c = 1'b0;
        shaf_rdata_c  = 32'h0;
        pad_done_c    = 1'b0;
        xfer          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hash_start_i) begin
                    state_d  = ST_PASS;
                    tx_cnt_d = '0;
                end
            end
            ST_PASS: begin
                if (aligned_end) begin
                    shaf_rvalid_c = 1'b1;
                    shaf_rdata_c  = 32'h8000_0000;
                end else begin
                    shaf_rvalid_c = fifo_rvalid_i;
                    shaf_rdata_c  = partial_end ? pad_word : fifo_rdata_i;
                    fifo_rready_c = shaf_rready_i;
                end
                xfer = shaf_rvalid_c && shaf_rready_i;
                if (xfer && (aligned_end || partial_end)) begin
                    state_d = ST_PAD00;
                end
            end
            ST_PAD00: begin
                shaf_rvalid_c = 1'b1;
                shaf_rdata_c  = (idx == 4'd14) ? len64[63:32] : 32'h0;
                xfer          = shaf_rready_i;
                if (xfer && (idx == 4'd14)) begin
                    state_d = ST_LENLO;
                end
            end
            ST_LENLO: begin
                shaf_rvalid_c = 1'b1;
                shaf_rdata_c  = len64[31:0];
                xfer          = shaf_rready_i;
                if (xfer) begin
                    pad_done_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer) begin
            tx_cnt_d = tx_cnt_q + LenW'(32);
        end

        if (hash_start_i && (state_q != ST_IDLE)) begin
            state_d     = ST_PASS;
            tx_cnt_d    = '0;
            proc_flag_d = hash_process_i;
        end

        if (state_d == ST_IDLE) begin
            proc_flag_d = 1'b0;
        end

        // Disable overrides everything, including a pending pad_done.
        if (!sha_en_i) begin
            state_d       = ST_IDLE;
            tx_cnt_d      = '0;
            proc_flag_d   = 1'b0;
            fifo_rready_c = 1'b0;
            shaf_rvalid_c = 1'b0;
            shaf_rdata_c  = 32'h0;
            pad_done_c    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tx_cnt_q    <= '0;
            proc_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            proc_flag_q <= proc_flag_d;
        end
    end

    assign fifo_rready_o = fifo_rready_c;
    assign shaf_rvalid_o = shaf_rvalid_c;
    assign shaf_rdata_o  = shaf_rdata_c;
    assign pad_done_o    = pad_done_c;

`ifdef SHA2_MSG_PAD_MASK_CHK_EN
    logic [3:0] exp_mask;
    logic       err_mask_c;

    always_comb begin
        exp_mask = 4'b1111;
        if (partial_end) begin
            case (tail_bytes)
                2'd1:    exp_mask = 4'b1000;
                2'd2:    exp_mask = 4'b1100;
                2'd3:    exp_mask = 4'b1110;
                default: exp_mask = 4'b1111;
            endcase
        end
        err_mask_c = (state_q == ST_PASS) && fifo_rvalid_i && fifo_rready_c &&
                     (fifo_rmask_i != exp_mask);
    end

    assign err_mask_o = err_mask_c;
`else
    logic unused_rmask;

    assign unused_rmask = ^fifo_rmask_i;
    assign err_mask_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sha2_msg_pad.sv
// tb/tb_sha2_msg_pad.sv - randomized bench for sha2_msg_pad against a byte-level padding model
module tb_sha2_msg_pad;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sha_en_i;
    logic        hash_start_i;
    logic        hash_process_i;
    logic [63:0] message_length_i;
    logic        fifo_rvalid_i;
    logic [31:0] fifo_rdata_i;
    logic [3:0]  fifo_rmask_i;
    logic        fifo_rready_o;
    logic        shaf_rvalid_o;
    logic [31:0] shaf_rdata_o;
    logic        shaf_rready_i;
    logic        pad_done_o;
    logic        err_mask_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  msg[$];
    logic [31:0] exp_q[$];
    logic [31:0] ent_data[$];
    logic [3:0]  ent_mask[$];
    bit          ent_bad[$];

    sha2_msg_pad #(.LenW(64)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sha_en_i        (sha_en_i),
        .hash_start_i    (hash_start_i),
        .hash_process_i  (hash_process_i),
        .message_length_i(message_length_i),
        .fifo_rvalid_i   (fifo_rvalid_i),
        .fifo_rdata_i    (fifo_rdata_i),
        .fifo_rmask_i    (fifo_rmask_i),
        .fifo_rready_o   (fifo_rready_o),
        .shaf_rvalid_o   (shaf_rvalid_o),
        .shaf_rdata_o    (shaf_rdata_o),
        .shaf_rready_i   (shaf_rready_i),
        .pad_done_o      (pad_done_o),
        .err_mask_o      (err_mask_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Message bytes, then 0x80, zeros to 56 mod 64, then 64-bit big-endian bit length.
    task automatic make_msg(input int nbytes, input int bad_word, input bit fixed_abc);
        logic [7:0]  p[$];
        logic [63:0] len;
        logic [31:0] d;
        logic [3:0]  m;
        int          nw;
        msg.delete();
        exp_q.delete();
        ent_data.delete();
        ent_mask.delete();
        ent_bad.delete();
        for (int i = 0; i < nbytes; i++) begin
            if (fixed_abc) msg.push_back(8'(8'h61 + i));
            else           msg.push_back(8'($urandom));
        end
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        len = 64'(nbytes) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(len >> (8 * k)));
        for (int i = 0; i < p.size() / 4; i++) begin
            exp_q.push_back({p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
        end
        nw = (nbytes + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = fixed_abc ? 32'h0 : $urandom;
            m = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < nbytes) begin
                    d[31 - 8*b -: 8] = msg[4*w + b];
                    m[3 - b]         = 1'b1;
                end
            end
            ent_bad.push_back(w == bad_word);
            if (w == bad_word) m = 4'b0111;
            ent_data.push_back(d);
            ent_mask.push_back(m);
        end
    endtask

    task automatic run_msg(input int nbytes, input bit bp, input int stop_after);
        int          fi;
        int          got;
        int          cyc;
        bit          hold;
        bit          prev_stall;
        logic [31:0] prev_data;
        bit          xfer;
        bit          pop;
        bit          exp_err;

        @(posedge clk_i); #1;
        sha_en_i         = 1'b1;
        hash_start_i     = 1'b1;
        message_length_i = 64'(nbytes) * 64'd8;
        fifo_rvalid_i    = 1'b0;
        shaf_rready_i    = 1'b0;
        @(posedge clk_i); #1;
        hash_start_i   = 1'b0;
        hash_process_i = 1'b1;
        @(posedge clk_i); #1;
        hash_process_i = 1'b0;

        fi = 0; got = 0; cyc = 0; hold = 0; prev_stall = 0; prev_data = 32'h0;
        while (1) begin
            if (got >= exp_q.size() || cyc >= 2000) break;
            if (stop_after >= 0 && got == stop_after) break;
            if (!hold) fifo_rvalid_i = !bp || ($urandom_range(0, 3) != 0);
            fifo_rdata_i  = (fi < ent_data.size()) ? ent_data[fi] : 32'hDEAD_BEEF;
            fifo_rmask_i  = (fi < ent_mask.size()) ? ent_mask[fi] : 4'hF;
            shaf_rready_i = !bp || ($urandom_range(0, 2) != 0);
            @(negedge clk_i);
            xfer = shaf_rvalid_o && shaf_rready_i;
            pop  = fifo_rvalid_i && fifo_rready_o;
`ifdef SHA2_MSG_PAD_MASK_CHK_EN
            exp_err = pop && (fi < ent_bad.size()) && ent_bad[fi];
`else
            exp_err = 1'b0;
`endif
            check("no_pop_while_stalled", 64'(fifo_rready_o && !shaf_rready_i), 64'd0);
            check("err_mask", 64'(err_mask_o), 64'(exp_err));
            if (prev_stall) check("stable_while_stalled", 64'(shaf_rdata_o), 64'(prev_data));
            if (pop) check("pop_within_message", 64'(fi < ent_data.size()), 64'd1);
            check("pad_done", 64'(pad_done_o), 64'(xfer && (got == exp_q.size() - 1)));
            if (xfer) begin
                check($sformatf("word%0d", got), 64'(shaf_rdata_o), 64'(exp_q[got]));
                got++;
            end
            prev_stall = shaf_rvalid_o && !shaf_rready_i;
            prev_data  = shaf_rdata_o;
            hold       = fifo_rvalid_i && !fifo_rready_o;
            if (pop) fi++;
            @(posedge clk_i); #1;
            cyc++;
        end

        if (stop_after < 0) begin
            check("word_count", 64'(got), 64'(exp_q.size()));
            check("pop_count", 64'(fi), 64'(ent_data.size()));
            fifo_rvalid_i = 1'b1;
            fifo_rdata_i  = 32'hDEAD_BEEF;
            shaf_rready_i = 1'b1;
            @(negedge clk_i);
            check("idle_valid", 64'(shaf_rvalid_o), 64'd0);
            check("idle_pop", 64'(fifo_rready_o), 64'd0);
        end else begin
            check("reached_stop_point", 64'(got), 64'(stop_after));
            sha_en_i      = 1'b0;
            shaf_rready_i = 1'b1;
            @(negedge clk_i);
            check("drop_pad_done", 64'(pad_done_o), 64'd0);
            @(posedge clk_i); #1;
            sha_en_i = 1'b1;
            @(negedge clk_i);
            check("drop_idle_valid", 64'(shaf_rvalid_o), 64'd0);
            check("drop_idle_pop", 64'(fifo_rready_o), 64'd0);
            check("drop_idle_done", 64'(pad_done_o), 64'd0);
        end
        @(posedge clk_i); #1;
        fifo_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_ni           = 1'b0;
        sha_en_i         = 1'b1;
        hash_start_i     = 1'b0;
        hash_process_i   = 1'b0;
        message_length_i = 64'd24;
        fifo_rvalid_i    = 1'b1;
        fifo_rdata_i     = 32'h1234_5678;
        fifo_rmask_i     = 4'hF;
        shaf_rready_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 64'(shaf_rvalid_o), 64'd0);
        check("rst_pop", 64'(fifo_rready_o), 64'd0);
        check("rst_data", 64'(shaf_rdata_o), 64'd0);
        check("rst_done", 64'(pad_done_o), 64'd0);
        check("rst_err", 64'(err_mask_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni        = 1'b1;
        fifo_rvalid_i = 1'b0;

        make_msg(3, -1, 1'b1);
        check("abc_model_word0", 64'(exp_q[0]), 64'h6162_6380);
        check("abc_model_mask", 64'(ent_mask[0]), 64'hE);
        run_msg(3, 1'b0, -1);

        make_msg(0, -1, 1'b0);
        run_msg(0, 1'b0, -1);

        make_msg(56, -1, 1'b0);
        check("m448_model_len", 64'(exp_q.size()), 64'd32);
        run_msg(56, 1'b0, -1);

        make_msg(3, -1, 1'b1);
        run_msg(3, 1'b1, -1);

        make_msg(3, -1, 1'b1);
        run_msg(3, 1'b0, 5);
        make_msg(3, -1, 1'b1);
        run_msg(3, 1'b0, -1);

        make_msg(20, 1, 1'b0);
        run_msg(20, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(0, 140);
            make_msg(n, -1, 1'b0);
            run_msg(n, 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
